// File: rtl/io_pkg.sv
// Shared constants for the board input conditioner: channel counts,
// default timing and the counter/prescaler sizing helper.
package io_pkg;

    // Number of push-buttons and slide switches on the board
    localparam int NBTN = 5;
    localparam int NSW  = 16;
    localparam int NCH  = NBTN + NSW;

    // Default timing: 1 ms sample tick at 100 MHz, four agreeing ticks to accept
    localparam int TICK_DIV_DEFAULT     = 100000;
    localparam int STABLE_TICKS_DEFAULT = 4;

    // Per-channel agreement counter width (covers STABLE_TICKS up to 15)
    localparam int CNT_W = 4;

    // Width needed for a counter that runs 0..div-1, never narrower than one bit
    function automatic int prescWidth(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: a two-flop synchroniser followed by a tick-sampled
// agreement counter that only accepts a new level after STABLE_TICKS
// consecutive ticks disagree with the current level.
module debounce_channel
    import io_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
)
(
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous pin into the clock domain through two flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // On each tick, count disagreeing samples and flip the level once enough agree
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (tick) begin
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_stable;

endmodule

// File: rtl/input_debounce.sv
// Board input conditioner: shared sample-tick prescaler, one debounce
// channel per button and switch, button rise pulses, sticky press-pending
// flags cleared from the bus, and the pending interrupt line.
module input_debounce
    import io_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_i,
    input  logic [NSW-1:0]  sw_i,
    input  logic            pend_clr_we,
    input  logic [NBTN-1:0] pend_clr_mask,
    output logic [NBTN-1:0] BTN_out,
    output logic [NSW-1:0]  SW_out,
    output logic [NBTN-1:0] btn_rise,
    output logic [NBTN-1:0] btn_pend,
    output logic            irq
);

    localparam int            PW         = prescWidth(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]   r_presc;
    logic            w_tick;
    logic [NCH-1:0]  w_raw;
    logic [NCH-1:0]  w_level;
    logic [NBTN-1:0] r_btnPrev;
    logic [NBTN-1:0] r_pend;
    logic [NBTN-1:0] w_rise;
    logic [NBTN-1:0] w_clr;

    // Free-running prescaler that wraps at TICK_DIV-1 to pace the sampling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = (r_presc == PRESC_LAST);

    // Buttons occupy the low channels, switches the high ones
    assign w_raw = {sw_i, btn_i};

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .tick (w_tick),
            .raw  (w_raw[g]),
            .level(w_level[g])
        );
    end

    assign BTN_out = w_level[NBTN-1:0];
    assign SW_out  = w_level[NCH-1:NBTN];

    // Remember last cycle's button levels so a new 1 can be spotted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btnPrev <= '0;
        end else begin
            r_btnPrev <= w_level[NBTN-1:0];
        end
    end

    // Both terms come straight from flops, so the pulse is clean and lines up
    // with the cycle in which the debounced level first reads 1
    assign w_rise   = w_level[NBTN-1:0] & ~r_btnPrev;
    assign btn_rise = w_rise;

    assign w_clr = pend_clr_we ? pend_clr_mask : '0;

    // Sticky press flags: a new press outranks a simultaneous bus clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_rise;
        end
    end

    assign btn_pend = r_pend;
    assign irq      = |r_pend;

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce with a small tick/window reference model,
// directed scenarios with literal expectations, and a randomized phase.
module tb_input_debounce;

    localparam int TD   = 4;
    localparam int ST   = 3;
    localparam int NB   = 5;
    localparam int NS   = 16;
    localparam int NC   = NB + NS;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btnIn;
    logic [NS-1:0] swIn;
    logic          pendClrWe;
    logic [NB-1:0] pendClrMask;
    logic [NB-1:0] btnOut;
    logic [NS-1:0] swOut;
    logic [NB-1:0] btnRise;
    logic [NB-1:0] btnPend;
    logic          irq;

    int total;
    int bad;
    bit checkEn;

    input_debounce #(
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_i        (btnIn),
        .sw_i         (swIn),
        .pend_clr_we  (pendClrWe),
        .pend_clr_mask(pendClrMask),
        .BTN_out      (btnOut),
        .SW_out       (swOut),
        .btn_rise     (btnRise),
        .btn_pend     (btnPend),
        .irq          (irq)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    int            mCycle;
    logic [NC-1:0] mS1;
    logic [NC-1:0] mS2;
    logic [NC-1:0] mStable;
    logic [NC-1:0] mNext;
    logic [NB-1:0] mRise;
    logic [NB-1:0] mPend;
    bit   [ST-1:0] mWin [NC];
    int            mSince [NC];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkRange(input string name, input int val, input int lo, input int hi);
        total++;
        if (val < lo || val > hi) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] b, input logic [NS-1:0] s,
                                 input logic we, input logic [NB-1:0] m);
        @(posedge clk);
        #1;
        btnIn       = b;
        swIn        = s;
        pendClrWe   = we;
        pendClrMask = m;
    endtask

    // Model: sample the two-cycle-delayed pin on every TD-th cycle since reset;
    // a level flips when the last ST samples since the previous flip all disagree
    always @(posedge clk) begin
        if (rst) begin
            mCycle  = 0;
            mS1     = '0;
            mS2     = '0;
            mStable = '0;
            mRise   = '0;
            mPend   = '0;
            for (int c = 0; c < NC; c++) begin
                mWin[c]   = '0;
                mSince[c] = 0;
            end
        end else begin
            mNext = mStable;
            if (mCycle % TD == TD - 1) begin
                for (int c = 0; c < NC; c++) begin
                    mWin[c] = {mWin[c][ST-2:0], mS2[c]};
                    mSince[c]++;
                    if (mSince[c] >= ST && mWin[c] == (mStable[c] ? {ST{1'b0}} : {ST{1'b1}})) begin
                        mNext[c]  = ~mStable[c];
                        mSince[c] = 0;
                    end
                end
            end
            mPend   = (mPend & ~(pendClrWe ? pendClrMask : {NB{1'b0}})) | mRise;
            mRise   = mNext[NB-1:0] & ~mStable[NB-1:0];
            mStable = mNext;
            mCycle++;
            mS2 = mS1;
            mS1 = {swIn, btnIn};
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_BTN_out", 32'(btnOut), 32'(mStable[NB-1:0]));
            checkOutput("model_SW_out", 32'(swOut), 32'(mStable[NC-1:NB]));
            checkOutput("model_btn_rise", 32'(btnRise), 32'(mRise));
            checkOutput("model_btn_pend", 32'(btnPend), 32'(mPend));
            checkOutput("model_irq", 32'(irq), 32'(|mPend));
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int lat;
        int pulses;
        logic [2:0] seen;

        total       = 0;
        bad         = 0;
        checkEn     = 0;
        rst         = 1'b1;
        btnIn       = 5'h1F;
        swIn        = 16'hFFFF;
        pendClrWe   = 1'b0;
        pendClrMask = '0;

        @(posedge clk);
        #1;
        checkEn = 1;

        // Reset hold with every input high
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("rstHold_all", {btnOut, swOut, btnRise, btnPend, irq}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (btnOut == 5'h1F) begin
                lat = k;
                break;
            end
        end
        checkRange("rstRelease_latency", lat, 11, 14);
        checkOutput("rstRelease_sw", 32'(swOut), 32'hFFFF);
        checkOutput("rstRelease_rise", 32'(btnRise), 32'h1F);
        @(negedge clk);
        checkOutput("rstRelease_riseGone", 32'(btnRise), 32'h0);
        checkOutput("rstRelease_pend", 32'(btnPend), 32'h1F);
        checkOutput("rstRelease_irq", 32'(irq), 32'h1);

        // Release everything and clear the pending flags
        applyStimulus(5'h00, 16'h0000, 1'b1, 5'h1F);
        applyStimulus(5'h00, 16'h0000, 1'b0, 5'h00);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("settle_levels", {11'h0, btnOut, swOut}, 32'h0);
        checkOutput("settle_pend", 32'(btnPend), 32'h0);

        // Clean press on button 0
        applyStimulus(5'h01, 16'h0000, 1'b0, 5'h00);
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (btnOut[0]) begin
                lat = k;
                break;
            end
        end
        checkRange("press_latency", lat, 11, 14);
        checkOutput("press_rise", 32'(btnRise), 32'h01);
        @(negedge clk);
        checkOutput("press_riseGone", 32'(btnRise), 32'h0);
        checkOutput("press_pend", 32'(btnPend), 32'h01);
        checkOutput("press_irq", 32'(irq), 32'h1);

        // Six-cycle glitch on button 1
        btnIn[1] = 1'b1;
        seen = '0;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) btnIn[1] = 1'b0;
            @(negedge clk);
            seen = seen | {btnOut[1], btnRise[1], btnPend[1]};
        end
        checkOutput("glitch_seen", 32'(seen), 32'h0);

        // Clear pending bit 0, then collide a clear with a new press on bit 2
        checkOutput("clear_pre", 32'(btnPend), 32'h01);
        applyStimulus(5'h01, 16'h0000, 1'b1, 5'h01);
        @(posedge clk);
        #1;
        pendClrWe   = 1'b0;
        pendClrMask = '0;
        @(negedge clk);
        checkOutput("clear_pend", 32'(btnPend), 32'h0);
        checkOutput("clear_irq", 32'(irq), 32'h0);
        applyStimulus(5'h05, 16'h0000, 1'b0, 5'h00);
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (btnRise[2]) begin
                lat = k;
                break;
            end
        end
        checkRange("collide_latency", lat, 11, 14);
        pendClrWe   = 1'b1;
        pendClrMask = 5'b00100;
        @(posedge clk);
        #1;
        pendClrWe   = 1'b0;
        pendClrMask = '0;
        @(negedge clk);
        checkOutput("collide_pend", 32'(btnPend), 32'h04);

        // Switch pattern in, then back out; no button activity expected
        applyStimulus(5'h05, 16'hA5A5, 1'b0, 5'h00);
        lat = 0;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (btnRise != 0) pulses++;
            if (swOut == 16'hA5A5) begin
                lat = k;
                break;
            end
        end
        checkRange("swOn_latency", lat, 11, 14);
        checkOutput("swOn_pendKept", 32'(btnPend), 32'h04);
        applyStimulus(5'h05, 16'h0000, 1'b0, 5'h00);
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (btnRise != 0) pulses++;
            if (swOut == 16'h0000) begin
                lat = k;
                break;
            end
        end
        checkRange("swOff_latency", lat, 11, 14);
        checkOutput("sw_risePulses", 32'(pulses), 32'h0);

        // Reset in the middle of a count on button 3
        applyStimulus(5'h00, 16'h0000, 1'b0, 5'h00);
        repeat (20) @(posedge clk);
        #1;
        btnIn = 5'h08;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midReset_all", {btnOut, swOut, btnRise, btnPend, irq}, 32'h0);
        lat = 0;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (btnRise[3]) pulses++;
            if (btnOut[3] && lat == 0) lat = k;
        end
        checkRange("midReset_latency", lat, 11, 14);
        checkOutput("midReset_pulses", 32'(pulses), 32'h1);
        checkOutput("midReset_pend", 32'(btnPend), 32'h08);

        // Randomized pins, clears and occasional resets against the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            btnIn       = btnIn ^ 5'($urandom & $urandom & $urandom & $urandom);
            swIn        = swIn ^ 16'($urandom & $urandom & $urandom & $urandom);
            pendClrWe   = ($urandom_range(0, 5) == 0);
            pendClrMask = 5'($urandom);
            rst         = ($urandom_range(0, 599) == 0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pendClrWe = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkEn = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
